// File: rtl/tiny_fpga_cfg_sequencer.sv
// Configuration sequencer for the tiny_fpga fabric.
// Takes bitstream bytes from the chip-level loader and serializes them LSB
// first onto the fabric cfg AXI-stream. It then waits, with a timeout, for
// cfg_ready and finally enables run.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              control pulses (abort has priority)
//   byte_data/valid/ready     byte input from the loader
//   cfg_tdata/tvalid/tready/tlast  bitstream stream to the fabric
//   cfg, cfg_ready            fabric configuration mode / completion
//   run                       fabric run enable
//   busy, error               status (error is sticky until start or rst)
module tiny_fpga_cfg_sequencer #(
  parameter int unsigned BITSTREAM_DATA_WIDTH = 1,
  parameter int unsigned BITSTREAM_LENGTH     = 64,
  parameter int unsigned READY_TIMEOUT        = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [7:0]                      byte_data,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  output logic [BITSTREAM_DATA_WIDTH-1:0] cfg_tdata,
  output logic                            cfg_tvalid,
  input  logic                            cfg_tready,
  output logic                            cfg_tlast,
  output logic                            cfg,
  input  logic                            cfg_ready,
  output logic                            run,
  output logic                            busy,
  output logic                            error
);

  localparam int unsigned TOTAL_BEATS = BITSTREAM_LENGTH / BITSTREAM_DATA_WIDTH;
  localparam int unsigned BYTE_BEATS  = 8 / BITSTREAM_DATA_WIDTH;
  localparam int unsigned BEAT_W      = $clog2(TOTAL_BEATS + 1);
  localparam int unsigned BBEAT_W     = $clog2(BYTE_BEATS + 1);
  localparam int unsigned TMO_W       = $clog2(READY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WAIT_READY,
    S_RUN,
    S_ERROR
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_nxt;
  logic [BEAT_W-1:0]    r_beat;
  logic [BEAT_W-1:0]    w_beat_nxt;
  logic [BBEAT_W-1:0]   r_bbeat;
  logic [BBEAT_W-1:0]   w_bbeat_nxt;
  logic [TMO_W-1:0]     r_tmo;
  logic [TMO_W-1:0]     w_tmo_nxt;

  logic                            r_byte_ready;
  logic [BITSTREAM_DATA_WIDTH-1:0] r_cfg_tdata;
  logic                            r_cfg_tvalid;
  logic                            r_cfg_tlast;
  logic                            r_cfg;
  logic                            r_run;
  logic                            r_busy;
  logic                            r_error;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_beat_nxt  = r_beat;
    w_bbeat_nxt = r_bbeat;
    w_tmo_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (!abort && start) begin
          w_state_nxt = S_LOAD;
          w_beat_nxt  = '0;
          w_bbeat_nxt = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_shift_nxt = '0;
          w_beat_nxt  = '0;
          w_bbeat_nxt = '0;
        end else if (byte_valid) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = byte_data;
          w_bbeat_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_shift_nxt = '0;
          w_beat_nxt  = '0;
          w_bbeat_nxt = '0;
        end else if (cfg_tready) begin
          w_shift_nxt = r_shift >> BITSTREAM_DATA_WIDTH;
          w_beat_nxt  = r_beat + BEAT_W'(1);
          w_bbeat_nxt = r_bbeat + BBEAT_W'(1);
          if (r_beat == BEAT_W'(TOTAL_BEATS - 1)) begin
            w_state_nxt = S_WAIT_READY;
          end else if (r_bbeat == BBEAT_W'(BYTE_BEATS - 1)) begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_WAIT_READY: begin
        // cfg_ready is checked before the limit so it wins a same-cycle tie.
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_shift_nxt = '0;
          w_beat_nxt  = '0;
          w_bbeat_nxt = '0;
        end else if (cfg_ready) begin
          w_state_nxt = S_RUN;
        end else if (r_tmo == TMO_W'(READY_TIMEOUT - 1)) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_beat_nxt  = '0;
          w_bbeat_nxt = '0;
        end else if (start) begin
          w_state_nxt = S_LOAD;
          w_beat_nxt  = '0;
          w_bbeat_nxt = '0;
        end
      end
      S_ERROR: begin
        if (!abort && start) begin
          w_state_nxt = S_LOAD;
          w_beat_nxt  = '0;
          w_bbeat_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_beat       <= '0;
      r_bbeat      <= '0;
      r_tmo        <= '0;
      r_byte_ready <= 1'b0;
      r_cfg_tdata  <= '0;
      r_cfg_tvalid <= 1'b0;
      r_cfg_tlast  <= 1'b0;
      r_cfg        <= 1'b0;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_beat       <= w_beat_nxt;
      r_bbeat      <= w_bbeat_nxt;
      r_tmo        <= w_tmo_nxt;
      r_byte_ready <= (w_state_nxt == S_LOAD);
      r_cfg_tvalid <= (w_state_nxt == S_SHIFT);
      r_cfg_tdata  <= (w_state_nxt == S_SHIFT) ? w_shift_nxt[BITSTREAM_DATA_WIDTH-1:0] : '0;
      r_cfg_tlast  <= (w_state_nxt == S_SHIFT) && (w_beat_nxt == BEAT_W'(TOTAL_BEATS - 1));
      r_cfg        <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT) ||
                      (w_state_nxt == S_WAIT_READY);
      r_busy       <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT) ||
                      (w_state_nxt == S_WAIT_READY);
      r_run        <= (w_state_nxt == S_RUN);
      r_error      <= (w_state_nxt == S_ERROR);
    end
  end

  assign byte_ready = r_byte_ready;
  assign cfg_tdata  = r_cfg_tdata;
  assign cfg_tvalid = r_cfg_tvalid;
  assign cfg_tlast  = r_cfg_tlast;
  assign cfg        = r_cfg;
  assign run        = r_run;
  assign busy       = r_busy;
  assign error      = r_error;

endmodule

// File: tb/tb_tiny_fpga_cfg_sequencer.sv
// Self-checking bench for tiny_fpga_cfg_sequencer (16-bit bitstream, 1-bit
// beats, 4-cycle ready timeout). Expected beats are queued as bytes are
// accepted and popped as beats are handshaked.
module tb_tiny_fpga_cfg_sequencer;

  localparam int unsigned TOTAL = 16;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic [0:0] cfg_tdata;
  logic       cfg_tvalid;
  logic       cfg_tready;
  logic       cfg_tlast;
  logic       cfg;
  logic       cfg_ready;
  logic       run;
  logic       busy;
  logic       error;

  int n_cmp;
  int n_bad;
  bit sb[$];

  tiny_fpga_cfg_sequencer #(
    .BITSTREAM_DATA_WIDTH (1),
    .BITSTREAM_LENGTH     (16),
    .READY_TIMEOUT        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cfg_tdata  (cfg_tdata),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tready (cfg_tready),
    .cfg_tlast  (cfg_tlast),
    .cfg        (cfg),
    .cfg_ready  (cfg_ready),
    .run        (run),
    .busy       (busy),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({pfx, "_tvalid"},     32'(cfg_tvalid), 32'd0);
    check({pfx, "_tlast"},      32'(cfg_tlast),  32'd0);
    check({pfx, "_tdata"},      32'(cfg_tdata),  32'd0);
    check({pfx, "_cfg"},        32'(cfg),        32'd0);
    check({pfx, "_run"},        32'(run),        32'd0);
    check({pfx, "_busy"},       32'(busy),       32'd0);
    check({pfx, "_error"},      32'(error),      32'd0);
  endtask

  // Feeds two bytes and checks every beat. Inputs are driven and outputs
  // sampled at the negedge; a handshake seen here completes on the next posedge.
  task automatic drive_stream(input logic [7:0] b0, input logic [7:0] b1,
                              input int stall_beat, input int stall_len,
                              input int abort_beat, input int start_beat,
                              input bit pre_ready);
    int         beats;
    int         idx;
    int         windows;
    int         stall_cnt;
    int         cycles;
    bit         prev_br;
    bit         stalled;
    bit         done;
    bit         exp_bit;
    logic [7:0] cur;
    sb.delete();
    beats = 0; idx = 0; windows = 0; stall_cnt = 0; cycles = 0;
    prev_br = 1'b0; done = 1'b0;
    while (!done) begin
      cur        = (idx == 0) ? b0 : b1;
      byte_data  = cur;
      byte_valid = (idx < 2);
      stalled    = (beats == stall_beat) && (stall_cnt < stall_len);
      if (stalled) stall_cnt++;
      cfg_tready = !stalled;
      start      = (beats == start_beat) && cfg_tvalid;
      cfg_ready  = pre_ready;
      if (abort_beat > 0 && beats == abort_beat - 1 && cfg_tvalid) begin
        abort      = 1'b1;
        cfg_tready = 1'b0;
        @(negedge clk);
        abort      = 1'b0;
        byte_valid = 1'b0;
        cfg_tready = 1'b1;
        check("abort_tvalid",     32'(cfg_tvalid), 32'd0);
        check("abort_cfg",        32'(cfg),        32'd0);
        check("abort_busy",       32'(busy),       32'd0);
        check("abort_tdata",      32'(cfg_tdata),  32'd0);
        check("abort_byte_ready", 32'(byte_ready), 32'd0);
        return;
      end
      if (byte_ready && !prev_br) windows++;
      prev_br = byte_ready;
      if (byte_ready && byte_valid) begin
        for (int i = 0; i < 8; i++) sb.push_back(cur[i]);
        idx++;
      end
      if (cfg_tvalid && cfg_tready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        exp_bit = (sb.size() != 0) ? sb.pop_front() : 1'b0;
        check("tdata", 32'(cfg_tdata), 32'(exp_bit));
        check("tlast", 32'(cfg_tlast), 32'(beats + 1 == TOTAL));
        beats++;
      end else if (stalled) begin
        check("stall_tvalid", 32'(cfg_tvalid), 32'd1);
        check("stall_tdata",  32'(cfg_tdata),  32'((sb.size() != 0) ? sb[0] : 1'b0));
        check("stall_tlast",  32'(cfg_tlast),  32'(beats + 1 == TOTAL));
      end
      cycles++;
      if (beats == TOTAL) begin
        done = 1'b1;
      end else if (cycles > 200) begin
        check("stream_timeout", 32'(beats), 32'(TOTAL));
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check("beats",    32'(beats),     32'(TOTAL));
    check("windows",  32'(windows),   32'd2);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  // Waits in WAIT_READY, raising cfg_ready in the given WAIT cycle.
  task automatic wait_run(input int ready_cycle, input bit poke_start);
    for (int c = 1; c <= ready_cycle; c++) begin
      @(negedge clk);
      cfg_ready = 1'b0;
      start     = 1'b0;
      check("wait_busy",   32'(busy),       32'd1);
      check("wait_cfg",    32'(cfg),        32'd1);
      check("wait_tvalid", 32'(cfg_tvalid), 32'd0);
      check("wait_run",    32'(run),        32'd0);
      if (poke_start && c == 1) start = 1'b1;
      if (c == ready_cycle) cfg_ready = 1'b1;
    end
    @(negedge clk);
    cfg_ready = 1'b0;
    start     = 1'b0;
    check("run_run",   32'(run),   32'd1);
    check("run_cfg",   32'(cfg),   32'd0);
    check("run_busy",  32'(busy),  32'd0);
    check("run_error", 32'(error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_data = 8'h00;
    byte_valid = 1'b0; cfg_tready = 1'b1; cfg_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic load, ready in the third WAIT cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_byte_ready", 32'(byte_ready), 32'd1);
    check("t1_cfg",        32'(cfg),        32'd1);
    drive_stream(8'hA5, 8'h3C, -1, 0, 0, -1, 1'b0);
    wait_run(3, 1'b0);

    // Reconfigure from RUN with backpressure and ignored starts; ready on the limit cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_run",        32'(run),        32'd0);
    check("t2_cfg",        32'(cfg),        32'd1);
    check("t2_byte_ready", 32'(byte_ready), 32'd1);
    drive_stream(8'h5A, 8'hC3, 3, 5, 0, 5, 1'b0);
    wait_run(4, 1'b1);

    // Timeout; cfg_ready held high before WAIT_READY is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_stream(8'hFF, 8'h00, -1, 0, 0, -1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cfg_ready = 1'b0;
      check("tmo_busy",  32'(busy),  32'd1);
      check("tmo_error", 32'(error), 32'd0);
    end
    @(negedge clk);
    check("err_error", 32'(error), 32'd1);
    check("err_cfg",   32'(cfg),   32'd0);
    check("err_run",   32'(run),   32'd0);
    check("err_busy",  32'(busy),  32'd0);
    @(negedge clk);
    check("err_sticky", 32'(error), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_clr_byte_ready", 32'(byte_ready), 32'd1);
    check("err_clr_error",      32'(error),      32'd0);

    // Abort at beat 7, then a full load from beat 1.
    drive_stream(8'h81, 8'h7E, -1, 0, 7, -1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_stream(8'h12, 8'h34, -1, 0, 0, -1, 1'b0);

    // Asynchronous reset in the middle of WAIT_READY.
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_quiet("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_stream(8'hDE, 8'hAD, -1, 0, 0, -1, 1'b0);
    wait_run(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
